demux_tdm_1_para_n: RTL and testbench

Time-division demultiplexer and the receive-side counterpart of the mux family. It takes a serial stream of LARGURA-bit words, framed by frame_sync, and routes each beat to one of N_CANAIS registered outputs by slot position. Its source is an upstream TDM mux/serialiser; its outputs feed the parallel ULA operand registers.

---
 rtl/demux_tdm_1_para_n_pkg.sv | 18 +
 rtl/demux_1_para_n.sv | 36 +++
 rtl/demux_tdm_1_para_n.sv | 138 +++++++++++++
 tb/tb_demux_tdm_1_para_n.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_tdm_1_para_n_pkg.sv
// Shared definitions for the TDM 1-to-N demultiplexer family:
// state encoding, slot-counter width helper and default geometry.
package demux_tdm_1_para_n_pkg;

    localparam int N_CANAIS_DEF = 4;
    localparam int LARGURA_DEF  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Slot counter width: max(1, clog2(n)).
    function automatic int slot_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_1_para_n.sv
// Combinational 1-to-N decoder: turns a slot index plus enable into a
// one-hot write strobe. Built from not/and gates as the dual of the
// mux primitives so it can be reused on its own.
module demux_1_para_n
    import demux_tdm_1_para_n_pkg::*;
#(
    parameter int N_OUT = N_CANAIS_DEF,
    parameter int SEL_W = slot_w(N_OUT)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_OUT-1:0] strobe
);

    wire [SEL_W-1:0] sel_n;

    for (genvar b = 0; b < SEL_W; b++) begin : g_inv
        not u_not (sel_n[b], sel[b]);
    end

    // Each output is en AND-ed with the true/complement literal of every
    // select bit that matches its own index.
    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        wire [SEL_W:0] chain;
        assign chain[0] = en;
        for (genvar b = 0; b < SEL_W; b++) begin : g_term
            if (((k >> b) & 1) == 1) begin : g_hi
                and u_and (chain[b+1], chain[b], sel[b]);
            end else begin : g_lo
                and u_and (chain[b+1], chain[b], sel_n[b]);
            end
        end
        assign strobe[k] = chain[SEL_W];
    end

endmodule

// File: rtl/demux_tdm_1_para_n.sv
// TDM demultiplexer: routes framed serial beats to N_CANAIS registered
// channel outputs by slot position. One cycle of latency, all outputs
// registered.
// Optional macro DEMUX_TDM_FRAME_BUF_EN: capture into shadow registers and
// publish the whole frame on dout at once when it completes.
module demux_tdm_1_para_n
    import demux_tdm_1_para_n_pkg::*;
#(
    parameter int N_CANAIS = N_CANAIS_DEF,
    parameter int LARGURA  = LARGURA_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LARGURA-1:0]           din,
    input  logic                         din_valid,
    input  logic                         frame_sync,
    output logic [N_CANAIS*LARGURA-1:0]  dout,
    output logic [N_CANAIS-1:0]          dout_valid,
    output logic                         frame_done,
    output logic                         sync_err
);

    localparam int SW = slot_w(N_CANAIS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CANAIS - 1);

    state_e                        state_q, state_d;
    logic [SW-1:0]                 slot_q, slot_d;
    logic [N_CANAIS*LARGURA-1:0]   dout_q, dout_d;
    logic [N_CANAIS-1:0]           dout_valid_q, dout_valid_d;
    logic                          frame_done_q, frame_done_d;
    logic                          sync_err_q, sync_err_d;

    logic                          wr_en;
    logic [SW-1:0]                 wr_slot;
    logic [N_CANAIS-1:0]           wr_strobe;

    // Frame FSM: decide which slot (if any) this beat writes and advance.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        slot_d       = slot_q;
        wr_en        = 1'b0;
        wr_slot      = slot_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                // A sync always starts a new frame; mid-frame it is an error.
                wr_en      = 1'b1;
                wr_slot    = '0;
                slot_d     = SW'(1);
                state_d    = ST_RUN;
                sync_err_d = (state_q == ST_RUN);
            end else if (state_q == ST_RUN) begin
                wr_en = 1'b1;
                if (slot_q == LAST_SLOT) begin
                    frame_done_d = 1'b1;
                    slot_d       = '0;
                    state_d      = ST_IDLE;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
        end
    end

    demux_1_para_n #(
        .N_OUT (N_CANAIS),
        .SEL_W (SW)
    ) u_dec (
        .sel    (wr_slot),
        .en     (wr_en),
        .strobe (wr_strobe)
    );

`ifdef DEMUX_TDM_FRAME_BUF_EN
    logic [N_CANAIS*LARGURA-1:0] shadow_q, shadow_d;

    // Collect beats in the shadow; publish the whole frame on completion.
    always_comb begin
        shadow_d = shadow_q;
        if (sync_err_d) begin
            // Aborted frame: drop whatever was collected so far.
            shadow_d = '0;
        end
        for (int k = 0; k < N_CANAIS; k++) begin
            if (wr_strobe[k]) shadow_d[k*LARGURA +: LARGURA] = din;
        end
        dout_d       = dout_q;
        dout_valid_d = '0;
        if (frame_done_d) begin
            dout_d       = shadow_d;
            dout_valid_d = '1;
        end
    end

    // Shadow register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end
`else
    // Write the selected channel field directly; others hold.
    always_comb begin
        dout_d = dout_q;
        for (int k = 0; k < N_CANAIS; k++) begin
            if (wr_strobe[k]) dout_d[k*LARGURA +: LARGURA] = din;
        end
        dout_valid_d = wr_strobe;
    end
`endif

    // State, slot counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_demux_tdm_1_para_n.sv
// Scoreboard bench for demux_tdm_1_para_n: a frame-level reference model
// pushes expected output events; a negedge monitor pops and compares them.
// Honours DEMUX_TDM_FRAME_BUF_EN the same way as the design.
module tb_demux_tdm_1_para_n;

    localparam int N = 4;
    localparam int L = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [L-1:0]     din;
    logic             din_valid;
    logic             frame_sync;
    logic [N*L-1:0]   dout;
    logic [N-1:0]     dout_valid;
    logic             frame_done;
    logic             sync_err;

    demux_tdm_1_para_n #(.N_CANAIS(N), .LARGURA(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*L-1:0] dout;
        logic [N-1:0]   valid;
        logic           done;
        logic           err;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit           in_frame;
    int           pos;
    logic [L-1:0] m_dout[N];
    logic [L-1:0] m_shadow[N];

    function automatic logic [N*L-1:0] pack_dout();
        logic [N*L-1:0] r;
        for (int k = 0; k < N; k++) r[k*L +: L] = m_dout[k];
        return r;
    endfunction

    task automatic model_reset();
        in_frame = 0;
        pos      = 0;
        for (int k = 0; k < N; k++) begin
            m_dout[k]   = '0;
            m_shadow[k] = '0;
        end
    endtask

    task automatic model_beat(input logic [L-1:0] d, input bit sync);
        exp_t         e;
        bit           done = 0;
        bit           err  = 0;
        bit           wr   = 0;
        int           ch   = 0;
        logic [N-1:0] v    = '0;
        if (sync) begin
            err = in_frame;
            `ifdef DEMUX_TDM_FRAME_BUF_EN
            if (err) for (int k = 0; k < N; k++) m_shadow[k] = '0;
            `endif
            in_frame = 1;
            wr = 1; ch = 0; pos = 1;
        end else if (in_frame) begin
            wr = 1; ch = pos;
            if (pos == N - 1) begin
                done = 1; in_frame = 0; pos = 0;
            end else begin
                pos++;
            end
        end
        if (wr) begin
            `ifdef DEMUX_TDM_FRAME_BUF_EN
            m_shadow[ch] = d;
            if (done) begin
                m_dout = m_shadow;
                v      = '1;
            end
            `else
            m_dout[ch] = d;
            v[ch]      = 1'b1;
            `endif
        end
        if (v != '0 || err) begin
            e.dout  = pack_dout();
            e.valid = v;
            e.done  = done;
            e.err   = err;
            sb.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    logic [N*L-1:0] last_dout = '0;
    int             done_cnt  = 0;
    int             err_cnt   = 0;
    bit             mon_en    = 0;
    exp_t           got;

    // Pop one expected event per DUT pulse; otherwise dout must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_done) done_cnt++;
            if (sync_err)   err_cnt++;
            if ((|dout_valid) || frame_done || sync_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {dout_valid, frame_done, sync_err}, '0);
                end else begin
                    got = sb.pop_front();
                    check("dout",       dout,       got.dout);
                    check("dout_valid", dout_valid, got.valid);
                    check("frame_done", frame_done, got.done);
                    check("sync_err",   sync_err,   got.err);
                    last_dout = got.dout;
                end
            end else begin
                check("dout_hold", dout, last_dout);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Entered and left at posedge+1; inputs are sampled by the edge in between.
    task automatic cyc(input bit valid, input logic [L-1:0] d, input bit sync);
        din        = d;
        din_valid  = valid;
        frame_sync = sync;
        if (valid) model_beat(d, sync);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, L'($urandom), 1'($urandom));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout"},       dout,       '0);
        check({tag, "_dout_valid"}, dout_valid, '0);
        check({tag, "_frame_done"}, frame_done, '0);
        check({tag, "_sync_err"},   sync_err,   '0);
    endtask

    int d0, e0;

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1;

        // 1: basic frame
        d0 = done_cnt; e0 = err_cnt;
        cyc(1, 8'hA0, 1); cyc(1, 8'hB1, 0); cyc(1, 8'hC2, 0); cyc(1, 8'hD3, 0);
        idle(2);
        check("s1_dout", dout, 32'hD3C2B1A0);
        check("s1_done_cnt", done_cnt - d0, 1);
        check("s1_err_cnt",  err_cnt - e0, 0);

        // 2: unsynced beats in IDLE are dropped
        d0 = done_cnt; e0 = err_cnt;
        cyc(1, 8'h55, 0); cyc(1, 8'h66, 0);
        cyc(1, 8'h01, 1); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0); cyc(1, 8'h04, 0);
        idle(2);
        check("s2_dout", dout, 32'h04030201);
        check("s2_err_cnt", err_cnt - e0, 0);

        // 3: premature sync
        d0 = done_cnt; e0 = err_cnt;
        cyc(1, 8'h11, 1); cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 1); cyc(1, 8'h44, 0); cyc(1, 8'h55, 0); cyc(1, 8'h66, 0);
        idle(2);
        check("s3_dout", dout, 32'h66554433);
        check("s3_err_cnt",  err_cnt - e0, 1);
        check("s3_done_cnt", done_cnt - d0, 1);

        // 4: gapped stream
        d0 = done_cnt;
        cyc(1, 8'h0A, 1); idle(3);
        cyc(1, 8'h0B, 0); idle(1);
        cyc(1, 8'h0C, 0); idle(2);
        cyc(1, 8'h0D, 0);
        idle(2);
        check("s4_dout", dout, 32'h0D0C0B0A);
        check("s4_done_cnt", done_cnt - d0, 1);

        // 5: back-to-back frames, then async reset mid third frame
        d0 = done_cnt; e0 = err_cnt;
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < N; s++) cyc(1, L'(8'h80 + f*16 + s), s == 0);
        cyc(1, 8'hE0, 1); cyc(1, 8'hE1, 0);
        din_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        sb.delete();
        model_reset();
        last_dout = '0;
        check("s5_done_cnt", done_cnt - d0, 2);
        check("s5_err_cnt",  err_cnt - e0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 8'hF1, 0); cyc(1, 8'hF2, 0);
        idle(1);
        check("s5_no_capture", dout, '0);
        cyc(1, 8'h21, 1); cyc(1, 8'h22, 0); cyc(1, 8'h23, 0); cyc(1, 8'h24, 0);
        idle(2);
        check("s5_dout", dout, 32'h24232221);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = in_frame ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            cyc(v, L'($urandom), s);
        end
        idle(3);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
